// File: rtl/epl_ffbank_rd_ser.sv
// epl_ffbank_rd_ser: snapshots a flop-bit bank on request and streams it out one bit per valid/ready beat; EPL_RDSER_PARITY_EN appends an even-parity beat
module epl_ffbank_rd_ser #(
  parameter int BANK_W = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W = $clog2(BANK_W + 1)
) (
  input  logic              pClk_i,
  input  logic              pRst_i,
  input  logic              pRdReq_i,
  input  logic [BANK_W-1:0] pBank_i,
  input  logic              pSrdy_i,
  output logic              pSvld_o,
  output logic              pSdo_o,
  output logic              pBusy_o,
  output logic              pDone_o,
  output logic              pDrop_o
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`ifdef EPL_RDSER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BANK_W);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BANK_W - 1);
`endif
  state_t state, stateNxt;
  logic [BANK_W-1:0] shadow, shadowNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic svldNxt, sdoNxt, busyNxt, doneNxt, dropNxt, xfer;
  function automatic logic beatBit(input logic [BANK_W-1:0] v, input logic [CNT_W-1:0] c);
    logic [BANK_W-1:0] s;
    s = (MSB_FIRST != 0) ? v >> (CNT_W'(BANK_W - 1) - c) : v >> c;
`ifdef EPL_RDSER_PARITY_EN
    if (c == LAST) return ^v;
`endif
    return s[0];
  endfunction
  assign xfer = pSvld_o & pSrdy_i;
  // Next-state decode; outputs are computed one cycle ahead so they leave the block registered
  always_comb begin
    stateNxt = state;
    shadowNxt = shadow;
    cntNxt = cnt;
    dropNxt = pDrop_o;
    svldNxt = 1'b0;
    sdoNxt = 1'b0;
    busyNxt = 1'b0;
    doneNxt = 1'b0;
    case (state)
      IDLE: if (pRdReq_i) begin
        stateNxt = SEND;
        shadowNxt = pBank_i;
        cntNxt = '0;
        dropNxt = 1'b0;
        svldNxt = 1'b1;
        sdoNxt = beatBit(pBank_i, '0);
        busyNxt = 1'b1;
      end
      SEND: begin
        dropNxt = pDrop_o | pRdReq_i;
        busyNxt = 1'b1;
        if (!xfer) begin
          svldNxt = 1'b1;
          sdoNxt = pSdo_o;
        end else if (cnt == LAST) begin
          stateNxt = DONE;
          doneNxt = 1'b1;
        end else begin
          cntNxt = cnt + CNT_W'(1);
          svldNxt = 1'b1;
          sdoNxt = beatBit(shadow, cnt + CNT_W'(1));
        end
      end
      DONE: begin
        dropNxt = pDrop_o | pRdReq_i;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end
  // State, snapshot and output registers; reset aborts any stream immediately
  always_ff @(posedge pClk_i or posedge pRst_i) begin
    if (pRst_i) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      pSvld_o <= 1'b0;
      pSdo_o <= 1'b0;
      pBusy_o <= 1'b0;
      pDone_o <= 1'b0;
      pDrop_o <= 1'b0;
    end else begin
      state <= stateNxt;
      shadow <= shadowNxt;
      cnt <= cntNxt;
      pSvld_o <= svldNxt;
      pSdo_o <= sdoNxt;
      pBusy_o <= busyNxt;
      pDone_o <= doneNxt;
      pDrop_o <= dropNxt;
    end
  end
endmodule

// File: tb/tb_epl_ffbank_rd_ser.sv
// tb_epl_ffbank_rd_ser: directed table-driven bench for epl_ffbank_rd_ser (LSB-first and MSB-first instances)
module tb_epl_ffbank_rd_ser;
`ifdef EPL_RDSER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  typedef struct {
    logic sel;
    logic [7:0] bank;
    logic [7:0] seq;
    logic par;
    int stallAt;
    int stallLen;
    int pulseAt;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, srdy = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] bank0 = '0, bank1 = '0;
  logic svld0, sdo0, busy0, done0, drop0;
  logic svld1, sdo1, busy1, done1, drop1;
  int checks = 0, failures = 0;
  vec_t tbl[8];
  always #5 clk = ~clk;
  epl_ffbank_rd_ser #(.BANK_W(8), .MSB_FIRST(0)) dutLsb (
    .pClk_i(clk), .pRst_i(rst), .pRdReq_i(req0), .pBank_i(bank0), .pSrdy_i(srdy),
    .pSvld_o(svld0), .pSdo_o(sdo0), .pBusy_o(busy0), .pDone_o(done0), .pDrop_o(drop0)
  );
  epl_ffbank_rd_ser #(.BANK_W(8), .MSB_FIRST(1)) dutMsb (
    .pClk_i(clk), .pRst_i(rst), .pRdReq_i(req1), .pBank_i(bank1), .pSrdy_i(srdy),
    .pSvld_o(svld1), .pSdo_o(sdo1), .pBusy_o(busy1), .pDone_o(done1), .pDrop_o(drop1)
  );
  function automatic logic [4:0] outs(input logic sel);
    return sel ? {svld1, sdo1, busy1, done1, drop1} : {svld0, sdo0, busy0, done0, drop0};
  endfunction
  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setReq(input logic sel, input logic val);
    if (sel) req1 = val; else req0 = val;
  endtask
  task automatic runRead(input int idx, input vec_t v);
    logic [4:0] o;
    logic e;
    if (v.sel) bank1 = v.bank; else bank0 = v.bank;
    setReq(v.sel, 1'b1);
    srdy = 1'b1;
    tick();
    setReq(v.sel, 1'b0);
    bank0 = ~v.bank;
    bank1 = ~v.bank;
    o = outs(v.sel);
    chk($sformatf("v%0d_acc_busy", idx), o[2], 1'b1);
    chk($sformatf("v%0d_acc_drop", idx), o[0], 1'b0);
    for (int b = 0; b < NB; b++) begin
      if (b == 8) e = v.par; else e = v.seq[b[2:0]];
      if (b == v.stallAt) begin
        srdy = 1'b0;
        for (int k = 0; k < v.stallLen; k++) begin
          tick();
          o = outs(v.sel);
          chk($sformatf("v%0d_b%0d_stall_vld", idx, b), o[4], 1'b1);
          chk($sformatf("v%0d_b%0d_stall_sdo", idx, b), o[3], e);
        end
        srdy = 1'b1;
      end
      if (b == v.pulseAt) setReq(v.sel, 1'b1);
      o = outs(v.sel);
      chk($sformatf("v%0d_b%0d_vld", idx, b), o[4], 1'b1);
      chk($sformatf("v%0d_b%0d_sdo", idx, b), o[3], e);
      chk($sformatf("v%0d_b%0d_nodone", idx, b), o[1], 1'b0);
      tick();
      setReq(v.sel, 1'b0);
    end
    o = outs(v.sel);
    chk($sformatf("v%0d_done", idx), o[1], 1'b1);
    chk($sformatf("v%0d_done_busy", idx), o[2], 1'b1);
    chk($sformatf("v%0d_done_vld", idx), o[4], 1'b0);
    chk($sformatf("v%0d_drop", idx), o[0], v.pulseAt < NB);
    tick();
    o = outs(v.sel);
    chk($sformatf("v%0d_idle_done", idx), o[1], 1'b0);
    chk($sformatf("v%0d_idle_busy", idx), o[2], 1'b0);
  endtask
  initial begin
    logic [7:0] s;
    logic e;
    tbl[0] = '{1'b0, 8'hA5, 8'hA5, 1'b0, 99, 0, 99};
    tbl[1] = '{1'b0, 8'h3C, 8'h3C, 1'b0, 2, 3, 99};
    tbl[2] = '{1'b1, 8'h81, 8'h81, 1'b0, 99, 0, 99};
    tbl[3] = '{1'b1, 8'h01, 8'h80, 1'b1, 0, 2, 99};
    tbl[4] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 99, 0, 3};
    tbl[5] = '{1'b0, 8'hF0, 8'hF0, 1'b0, 7, 1, 99};
    tbl[6] = '{1'b1, 8'hF0, 8'h0F, 1'b0, 99, 0, 99};
    tbl[7] = '{1'b0, 8'h07, 8'h07, 1'b1, 8, 2, 99};
    #1;
    chk("rst_vld", svld0, 1'b0);
    chk("rst_sdo", sdo0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_drop", drop0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy0, 1'b0);
    chk("post_rst_vld1", svld1, 1'b0);
    for (int i = 0; i < 8; i++) runRead(i, tbl[i]);
    // reset in the middle of a stream
    bank0 = 8'hFF;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (4) tick();
    chk("mid_vld", svld0, 1'b1);
    chk("mid_sdo", sdo0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", svld0, 1'b0);
    chk("arst_sdo", sdo0, 1'b0);
    chk("arst_busy", busy0, 1'b0);
    tick();
    chk("arst_nodone", done0, 1'b0);
    rst = 1'b0;
    tick();
    chk("arst_rel_done", done0, 1'b0);
    chk("arst_rel_busy", busy0, 1'b0);
    runRead(100, tbl[0]);
    // request held high: back-to-back reads on the MSB-first instance
    s = 8'h40;
    bank1 = 8'h02;
    req1 = 1'b1;
    srdy = 1'b1;
    tick();
    chk("hold_busy", busy1, 1'b1);
    chk("hold_drop0", drop1, 1'b0);
    for (int b = 0; b < NB; b++) begin
      if (b == 8) e = 1'b1; else e = s[b[2:0]];
      chk($sformatf("hold_b%0d_vld", b), svld1, 1'b1);
      chk($sformatf("hold_b%0d_sdo", b), sdo1, e);
      tick();
      if (b == 0) chk("hold_drop_set", drop1, 1'b1);
    end
    chk("hold_done", done1, 1'b1);
    tick();
    chk("hold_gap_busy", busy1, 1'b0);
    chk("hold_gap_drop", drop1, 1'b1);
    tick();
    chk("hold_rd2_vld", svld1, 1'b1);
    chk("hold_rd2_drop", drop1, 1'b0);
    req1 = 1'b0;
    repeat (NB) tick();
    chk("hold_rd2_done", done1, 1'b1);
    tick();
    chk("hold_rd2_idle", busy1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/epl_ffbank_rd_ser.md
Name: epl_ffbank_rd_ser

Overview:
- Read-side counterpart of the write-enabled flop-bit cells.
- On a read request, snapshots a bank of BANK_W flop-bit outputs into a shadow register.
- Streams the snapshot out one bit per transfer over a valid/ready serial interface, then signals completion.
- Sits between a bank of write-enabled status/config bits and a serial readback/debug path.

Parameters:
- BANK_W, 8, number of flop bits in the bank; legal range 2..64.
- MSB_FIRST, 0, 0 = send bit 0 first; 1 = send bit BANK_W-1 first.
- CNT_W, $clog2(BANK_W+1), bit-counter width; derived, do not override.

Ports:
- pClk_i  input  1  clock; all state changes on the rising edge.
- pRst_i  input  1  reset; asynchronous, active-high; clears all state.
- pRdReq_i  input  1  read request; sampled only in IDLE.
- pBank_i  input  BANK_W  live outputs of the flop-bit bank.
- pSrdy_i  input  1  serial sink ready.
- pSvld_o  output  1  serial data valid.
- pSdo_o  output  1  serial data bit.
- pBusy_o  output  1  high while not in IDLE.
- pDone_o  output  1  one-cycle pulse after the last beat is accepted.
- pDrop_o  output  1  sticky flag: a request arrived while busy.

Behaviour:
- Reset (async assert, state cleared immediately):
  - pSvld_o=0, pSdo_o=0, pBusy_o=0, pDone_o=0, pDrop_o=0.
  - Shadow register=0, counter=0, state=IDLE.
- Reset release: first active edge starts in IDLE.
- States: IDLE, SEND, DONE. All outputs are registered.
- IDLE:
  - If pRdReq_i=1: capture pBank_i into the shadow register, counter=0, clear pDrop_o, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - Entered on the edge that samples pRdReq_i, so pSvld_o=1 on the next cycle (latency 1).
  - pSdo_o = shadow[counter] when MSB_FIRST=0; shadow[BANK_W-1-counter] when MSB_FIRST=1.
  - Beat transfer = pSvld_o & pSrdy_i at the rising edge.
  - On transfer with counter<LAST: counter+1; next bit is presented in the following cycle with pSvld_o still 1 (no bubble).
  - On transfer with counter==LAST: go to DONE, pSvld_o=0.
  - LAST = BANK_W-1; see Optional Feature for the parity case.
  - While pSvld_o=1 and pSrdy_i=0: pSdo_o and counter hold; pSvld_o stays 1 (no retraction).
- DONE:
  - pDone_o=1 for exactly one cycle, pBusy_o=1, pSvld_o=0.
  - Unconditional return to IDLE.
  - A new request is accepted at the earliest on the cycle after DONE.
- pBusy_o = 1 in SEND and DONE, 0 in IDLE.
- pRdReq_i=1 in SEND or DONE:
  - Request is ignored and not queued; pDrop_o is set to 1.
  - pDrop_o stays 1 until the next accepted request clears it.
- pBank_i changes after capture do not affect the stream; the snapshot is coherent for the whole read.
- pRdReq_i held high continuously: back-to-back reads, each separated by the DONE cycle, with pDrop_o set during each read.
- pSrdy_i outside SEND: ignored.
- Counter never exceeds LAST; no wrap-around in normal operation.
- Reset asserted mid-SEND: stream aborts immediately, all outputs return to reset values, no pDone_o pulse.

Optional Feature:
- Macro: EPL_RDSER_PARITY_EN.
- Defined:
  - After the last data beat, one extra beat carries even parity (XOR of all shadow bits).
  - LAST = BANK_W; total beats = BANK_W+1.
  - pDone_o follows acceptance of the parity beat.
  - Parity beat obeys the same valid/ready hold rules as data beats.
- Undefined: exactly BANK_W data beats; no parity logic is instantiated.

Test Plan:
- Basic read: BANK_W=8, MSB_FIRST=0, pBank_i=8'hA5, pSrdy_i=1, one-cycle pRdReq_i -> pSvld_o high for 8 consecutive cycles starting 1 cycle after request; pSdo_o=1,0,1,0,0,1,0,1; pDone_o pulses 1 cycle after the last beat; pBusy_o high for 9 cycles.
- Backpressure: pBank_i=8'h3C, pSrdy_i low for 3 cycles during beat 2 -> pSdo_o holds 1 and pSvld_o stays high through the stall; full sequence 0,0,1,1,1,1,0,0 delivered intact.
- Snapshot coherence and drop: request with pBank_i=8'hFF, then drive 8'h00 and pulse pRdReq_i mid-stream -> all 8 beats =1, pDrop_o=1 after the second pulse, pDrop_o cleared by the next request accepted in IDLE.
- MSB_FIRST=1, pBank_i=8'h81, pSrdy_i=1 -> pSdo_o sequence 1,0,0,0,0,0,0,1.
- Reset mid-operation: assert pRst_i during beat 4 -> pSvld_o, pBusy_o, pSdo_o =0 immediately (asynchronous), no pDone_o pulse; after release, a fresh request streams correctly.
- EPL_RDSER_PARITY_EN defined, pBank_i=8'h07 -> 9 beats: 1,1,1,0,0,0,0,0 then parity 1; pDone_o pulses after beat 9.
